assert_ctrl_responder: RTL and testbench
========================================

# assert_ctrl_responder

Synthesizable assertion responder: the checker-side end of the assertion-control interface. A controller issues on/off/freeze/thaw/kill commands through a valid/ready channel. The block obeys those commands while it evaluates one bounded-latency property, `req |-> ##[1:MAX_LAT] ack`, with an enable-style abort that acts like `disable iff`. It reports pass/fail pulses, saturating counters and a first-failure timestamp, and sits beside the monitored interface in simulation and emulation builds.

## Interface
- MAX_LAT, 4: maximum cycles from req to ack; legal range 1..15.
- CNT_W, 8: width of pass/fail counters.
- TS_W, 16: width of free-running cycle timestamp.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  3  0 NOP, 1 OFF, 2 ON, 3 FREEZE, 4 THAW, 5 KILL, 6 CLR; 7 is treated as NOP.
- chk_en  in  1  evaluation enable; low aborts the pending attempt.
- req  in  1  antecedent.
- ack  in  1  consequent.
- pass_o / fail_o  out  1 each  one-cycle result pulses.
- pass_cnt / fail_cnt  out  CNT_W each  saturating counts.
- first_fail_vld  out  1  first_fail_ts holds a valid value.
- first_fail_ts  out  TS_W  timestamp of first failure.
- state_o  out  2  0 OFF, 1 ON, 2 FROZEN.
- busy_o  out  1  attempt pending.

## Operation
- Control FSM, reset state ON:
  - OFF: ON→ON.
  - ON: OFF→OFF; FREEZE→FROZEN.
  - FROZEN: THAW or ON→ON, resuming with the pending attempt intact; OFF→OFF.
  - All other (state, op) pairs leave the state unchanged.
- Entering OFF discards the pending attempt.
- KILL discards the pending attempt and keeps the state.
- CLR zeroes both counters and first_fail_vld, and keeps the state.
- Tracker has two states, IDLE and PEND, with lat counter 1..MAX_LAT. It advances only in ON with chk_en=1:
  - IDLE & req: go to PEND with lat=1.
  - PEND & ack: pass; go to IDLE.
  - PEND & !ack & lat==MAX_LAT: fail; go to IDLE.
  - Otherwise: lat+1.
- Completion and new req in the same cycle: the new attempt starts in that cycle (back-to-back).
- req while PEND and not completing: ignored. At most one attempt is outstanding.
- ack in the req cycle does not count; the earliest valid ack is in the next cycle.
- ON with chk_en=0: PEND goes to IDLE silently, with no pass/fail.
- FROZEN: tracker, lat, counters and timestamp capture all hold. req, ack and chk_en are ignored. The cycle counter keeps running.
- Counters saturate at all-ones.
- Cycle counter: TS_W bits, wraps. It is captured into first_fail_ts on a fail only when first_fail_vld=0.

## Timing
- Reset values:
  - cmd_ready=1; state_o=1; busy_o=0.
  - pass_o=0; fail_o=0.
  - counters=0; first_fail_vld=0; first_fail_ts=0.
  - cycle counter=0; tracker IDLE.
- A command is accepted at edge E. The new state applies from E onward. Tracker evaluation sampled at E uses the pre-E state.
- cmd_ready drops for the one cycle after each accepted command (non-NOP and NOP alike), then returns high. Max throughput is one command per two cycles.
- pass_o / fail_o are registered. They are high in the cycle after the deciding sample edge. Counters and first_fail_ts update on that same edge.
- Fail latency: req sampled at edge N with ack low through edge N+MAX_LAT gives fail_o high in the cycle after N+MAX_LAT.
- first_fail_ts equals the cycle-counter value at the deciding edge.
- Same-edge cases:
  - CLR on the same edge as a fail: the fail wins. Counter=1, first_fail captured.
  - KILL on the same edge as a completing sample: the completion is reported, and no new attempt starts on that edge.
  - Rising rst mid-attempt: everything returns to reset values asynchronously. No pulse is emitted.

## Configuration
- ASSERT_CTRL_MSG_EN defined: the block adds non-synthesizable reporting:
  - `$error` with timestamp on each fail.
  - `$display` on each state change.
  - `$warning` on cmd_op=7.
- Not defined: no messages, no other behavioural change; outputs are identical in both builds.

## Structure
- assert_ctrl_pkg holds:
  - the cmd_op enum;
  - the control state enum (OFF/ON/FROZEN);
  - the tracker enum (IDLE/PEND);
  - the op-code width constant.
- Sub-module assert_ctrl_sat_cnt is a parameterized saturating counter with sync clear and enable. It is instantiated for pass_cnt and fail_cnt.

## Test plan
All scenarios use MAX_LAT=4.
- Pass: reset released, req at edge 10, ack at edge 12 → pass_o high for one cycle after edge 12, pass_cnt=1, fail_cnt=0.
- Fail: req at edge 20, ack never → fail_o after edge 24, fail_cnt=1, first_fail_ts=24. Second fail at edge 34 → fail_cnt=2, first_fail_ts still 24.
- OFF/ON: OFF accepted, then req at 40 with no ack for 10 cycles → no fail_o. Then ON → counters unchanged, state_o=1, cmd_ready low for exactly one cycle after each accept.
- Freeze: req at 50, FREEZE at edge 52 (lat=2), ack high for 20 cycles while frozen → busy_o=1 and no pass. THAW, then ack low → fail at the 2nd edge after thaw. Repeat with ack at the 1st edge after thaw → pass.
- Abort: chk_en low during PEND → busy_o=0, no pulses. KILL during PEND → same. CLR on the fail edge → fail_cnt=1.
- Boundaries: CNT_W=2 with 5 fails → fail_cnt=3. Async rst at lat=3 → all outputs at reset values before the next edge. Back-to-back: req at completion edge → new attempt starts, busy_o stays 1.

Source files
------------

// File: rtl/assert_ctrl_pkg.sv
// Shared types for the assertion-control responder: command codes, control
// states, tracker states and the control-state transition function.
package assert_ctrl_pkg;

   localparam int unsigned OP_W = 3;
   localparam int unsigned ST_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOP    = 3'd0,
      OP_OFF    = 3'd1,
      OP_ON     = 3'd2,
      OP_FREEZE = 3'd3,
      OP_THAW   = 3'd4,
      OP_KILL   = 3'd5,
      OP_CLR    = 3'd6,
      OP_RSVD   = 3'd7
   } cmd_op_e;

   typedef enum logic [ST_W-1:0] {
      ST_OFF    = 2'd0,
      ST_ON     = 2'd1,
      ST_FROZEN = 2'd2
   } ctrl_state_e;

   typedef enum logic {
      TRK_IDLE = 1'b0,
      TRK_PEND = 1'b1
   } trk_state_e;

   // Control state after an accepted command; unlisted pairs hold the state.
   function automatic ctrl_state_e ctrl_next(input ctrl_state_e cur, input cmd_op_e op);
      ctrl_state_e nxt;
      nxt = cur;
      case (cur)
         ST_OFF: begin
            if (op == OP_ON) nxt = ST_ON;
         end
         ST_ON: begin
            if (op == OP_OFF)         nxt = ST_OFF;
            else if (op == OP_FREEZE) nxt = ST_FROZEN;
         end
         ST_FROZEN: begin
            if (op == OP_THAW || op == OP_ON) nxt = ST_ON;
            else if (op == OP_OFF)            nxt = ST_OFF;
         end
         default: nxt = ST_ON;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/assert_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment coinciding with
// a clear leaves the count at one.
module assert_ctrl_sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= i_en ? W'(1) : '0;
      end else if (i_en && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/assert_ctrl_responder.sv
// Checker-side assertion-control responder evaluating req |-> ##[1:MAX_LAT] ack.
// Define ASSERT_CTRL_MSG_EN to add simulation-only fail/state/opcode messages.
module assert_ctrl_responder
   import assert_ctrl_pkg::*;
#(
   parameter int unsigned MAX_LAT = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TS_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic             chk_en,
   input  logic             req,
   input  logic             ack,
   output logic             pass_o,
   output logic             fail_o,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             first_fail_vld,
   output logic [TS_W-1:0]  first_fail_ts,
   output logic [ST_W-1:0]  state_o,
   output logic             busy_o
);

   localparam int unsigned LAT_W = 4;

   ctrl_state_e      r_state, w_state_nxt;
   trk_state_e       r_trk, w_trk_nxt;
   logic [LAT_W-1:0] r_lat, w_lat_nxt;
   logic             r_cmd_ready, r_pass, r_fail;
   logic             r_ff_vld;
   logic [TS_W-1:0]  r_cycle, r_ff_ts;
   logic             w_acc, w_kill, w_clr, w_discard, w_pass, w_fail;
   cmd_op_e          w_op;

   assign w_op  = cmd_op_e'(cmd_op);
   assign w_acc = cmd_valid & r_cmd_ready;

   // Command decode and control next state
   always_comb begin
      w_state_nxt = r_state;
      w_kill      = 1'b0;
      w_clr       = 1'b0;
      w_discard   = 1'b0;
      if (w_acc) begin
         w_state_nxt = ctrl_next(r_state, w_op);
         w_kill      = (w_op == OP_KILL);
         w_clr       = (w_op == OP_CLR);
      end
      w_discard = w_kill || ((w_state_nxt == ST_OFF) && (r_state != ST_OFF));
   end

   // Tracker next state; evaluation uses the control state from before this edge
   always_comb begin
      w_trk_nxt = r_trk;
      w_lat_nxt = r_lat;
      w_pass    = 1'b0;
      w_fail    = 1'b0;
      case (r_state)
         ST_ON: begin
            if (!chk_en) begin
               w_trk_nxt = TRK_IDLE;
            end else if (r_trk == TRK_IDLE) begin
               if (req) begin
                  w_trk_nxt = TRK_PEND;
                  w_lat_nxt = LAT_W'(1);
               end
            end else begin
               if (ack)                              w_pass = 1'b1;
               else if (r_lat == LAT_W'(MAX_LAT))    w_fail = 1'b1;
               if (w_pass || w_fail) begin
                  if (req) w_lat_nxt = LAT_W'(1);
                  else     w_trk_nxt = TRK_IDLE;
               end else begin
                  w_lat_nxt = r_lat + LAT_W'(1);
               end
            end
         end
         ST_FROZEN: begin
         end
         default: w_trk_nxt = TRK_IDLE;
      endcase
      // A discard still lets this edge's completion report, but drops any restart
      if (w_discard) w_trk_nxt = TRK_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_ON;
         r_trk       <= TRK_IDLE;
         r_lat       <= '0;
         r_cmd_ready <= 1'b1;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_cycle     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_trk       <= w_trk_nxt;
         r_lat       <= w_lat_nxt;
         r_cmd_ready <= ~w_acc;
         r_pass      <= w_pass;
         r_fail      <= w_fail;
         r_cycle     <= r_cycle + TS_W'(1);
      end
   end

   // First-failure capture; a fail on the clearing edge re-arms and captures
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ff_vld <= 1'b0;
         r_ff_ts  <= '0;
      end else if (w_fail && (!r_ff_vld || w_clr)) begin
         r_ff_vld <= 1'b1;
         r_ff_ts  <= r_cycle;
      end else if (w_clr) begin
         r_ff_vld <= 1'b0;
      end
   end

   assert_ctrl_sat_cnt #(.W(CNT_W)) u_pass_cnt (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (w_clr),
      .i_en  (w_pass),
      .o_cnt (pass_cnt)
   );

   assert_ctrl_sat_cnt #(.W(CNT_W)) u_fail_cnt (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (w_clr),
      .i_en  (w_fail),
      .o_cnt (fail_cnt)
   );

   assign cmd_ready      = r_cmd_ready;
   assign pass_o         = r_pass;
   assign fail_o         = r_fail;
   assign first_fail_vld = r_ff_vld;
   assign first_fail_ts  = r_ff_ts;
   assign state_o        = r_state;
   assign busy_o         = (r_trk == TRK_PEND);

`ifdef ASSERT_CTRL_MSG_EN
   always @(posedge clk) begin
      if (!rst) begin
         if (w_fail)
            $error("assert_ctrl_responder: req |-> ack failed at cycle %0d", r_cycle);
         if (w_state_nxt != r_state)
            $display("assert_ctrl_responder: state %0d -> %0d at cycle %0d", r_state, w_state_nxt, r_cycle);
         if (w_acc && (w_op == OP_RSVD))
            $warning("assert_ctrl_responder: reserved cmd_op 7 treated as NOP at cycle %0d", r_cycle);
      end
   end
`else
   // Silent build: outputs identical, no reporting.
`endif

endmodule

// File: tb/tb_assert_ctrl_responder.sv
// Directed bench: stimulus pushes expected pass/fail pulses into a scoreboard
// that a negedge monitor pops; a CNT_W=2 twin checks counter saturation.
module tb_assert_ctrl_responder;
   import assert_ctrl_pkg::*;

   localparam int unsigned MAX_LAT = 4;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned TS_W    = 16;
   localparam int unsigned SCNT_W  = 2;

   logic              clk, rst, cmd_valid, chk_en, req, ack;
   logic [OP_W-1:0]   cmd_op;
   logic              cmd_ready, pass_o, fail_o, first_fail_vld, busy_o;
   logic [CNT_W-1:0]  pass_cnt, fail_cnt;
   logic [TS_W-1:0]   first_fail_ts;
   logic [ST_W-1:0]   state_o;

   logic              s_cmd_ready, s_pass_o, s_fail_o, s_ff_vld, s_busy_o;
   logic [SCNT_W-1:0] s_pass_cnt, s_fail_cnt;
   logic [TS_W-1:0]   s_ff_ts;
   logic [ST_W-1:0]   s_state_o;

   int checks = 0;
   int errors = 0;
   int last_edge = -1;

   typedef struct {
      bit is_fail;
      int edge_n;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   assert_ctrl_responder #(.MAX_LAT(MAX_LAT), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .chk_en(chk_en), .req(req), .ack(ack), .pass_o(pass_o), .fail_o(fail_o),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_vld(first_fail_vld),
      .first_fail_ts(first_fail_ts), .state_o(state_o), .busy_o(busy_o)
   );

   assert_ctrl_responder #(.MAX_LAT(MAX_LAT), .CNT_W(SCNT_W), .TS_W(TS_W)) dut_small (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op),
      .chk_en(chk_en), .req(req), .ack(ack), .pass_o(s_pass_o), .fail_o(s_fail_o),
      .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .first_fail_vld(s_ff_vld),
      .first_fail_ts(s_ff_ts), .state_o(s_state_o), .busy_o(s_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge numbering matches the DUT cycle counter sampled at that edge
   always @(posedge clk or posedge rst) begin
      if (rst) last_edge <= -1;
      else     last_edge <= last_edge + 1;
   end

   always @(negedge clk) begin
      if (!rst && (pass_o || fail_o)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse pass=%0b fail=%0b at edge %0d, required no pulse", pass_o, fail_o, last_edge);
         end else begin
            mon_e = sb.pop_front();
            if ((pass_o !== !mon_e.is_fail) || (fail_o !== mon_e.is_fail) || (last_edge != mon_e.edge_n)) begin
               errors++;
               $display("FAIL result_pulse actual pass=%0b fail=%0b edge=%0d, required %s at edge %0d",
                        pass_o, fail_o, last_edge, mon_e.is_fail ? "fail" : "pass", mon_e.edge_n);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired at edge %0d", last_edge);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, last_edge);
      end
   endtask

   task automatic expect_ev(input bit is_fail, input int edge_n);
      exp_t e;
      e.is_fail = is_fail;
      e.edge_n  = edge_n;
      sb.push_back(e);
   endtask

   // Return at the negedge preceding edge n, so inputs set now are sampled at n
   task automatic goto(input int n);
      int guard;
      guard = 0;
      while ((last_edge != n - 1) && (guard < 500)) begin
         @(negedge clk);
         guard++;
      end
      if (last_edge != n - 1) begin
         checks++;
         errors++;
         $display("FAIL goto_timeout actual=%0d required=%0d", last_edge, n - 1);
      end
   endtask

   task automatic issue(input cmd_op_e op);
      cmd_valid = 1'b1;
      cmd_op    = op;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
      chk({tag, "_state"}, 32'(state_o), 1);
      chk({tag, "_busy"}, 32'(busy_o), 0);
      chk({tag, "_pass_o"}, 32'(pass_o), 0);
      chk({tag, "_fail_o"}, 32'(fail_o), 0);
      chk({tag, "_pass_cnt"}, 32'(pass_cnt), 0);
      chk({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
      chk({tag, "_ff_vld"}, 32'(first_fail_vld), 0);
      chk({tag, "_ff_ts"}, 32'(first_fail_ts), 0);
      chk({tag, "_small_fail_cnt"}, 32'(s_fail_cnt), 0);
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; chk_en = 1'b1; req = 1'b0; ack = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      reset_checks("reset");
      rst = 1'b0;

      // Pass: req at 10, ack at 12
      expect_ev(1'b0, 12);
      goto(10); req = 1'b1;
      goto(11); req = 1'b0;
      chk("pend_busy", 32'(busy_o), 1);
      goto(12); ack = 1'b1;
      goto(13); ack = 1'b0;
      chk("pass1_pass_cnt", 32'(pass_cnt), 1);
      chk("pass1_fail_cnt", 32'(fail_cnt), 0);

      // Two fails; first timestamp held at 24
      expect_ev(1'b1, 24);
      goto(20); req = 1'b1;
      goto(21); req = 1'b0;
      goto(25);
      chk("fail1_cnt", 32'(fail_cnt), 1);
      chk("fail1_ff_vld", 32'(first_fail_vld), 1);
      chk("fail1_ff_ts", 32'(first_fail_ts), 24);
      expect_ev(1'b1, 34);
      goto(30); req = 1'b1;
      goto(31); req = 1'b0;
      goto(36);
      chk("fail2_cnt", 32'(fail_cnt), 2);
      chk("fail2_ff_ts", 32'(first_fail_ts), 24);

      // OFF ignores req; ON restores; cmd_ready drops one cycle per accept
      goto(38); issue(OP_OFF);
      goto(39); cmd_valid = 1'b0;
      chk("off_ready_low", 32'(cmd_ready), 0);
      chk("off_state", 32'(state_o), 0);
      goto(40); req = 1'b1;
      chk("off_ready_back", 32'(cmd_ready), 1);
      goto(41); req = 1'b0;
      chk("off_busy", 32'(busy_o), 0);
      goto(52); issue(OP_ON);
      goto(53); cmd_valid = 1'b0;
      chk("on_state", 32'(state_o), 1);
      chk("on_ready_low", 32'(cmd_ready), 0);
      chk("on_pass_cnt", 32'(pass_cnt), 1);
      chk("on_fail_cnt", 32'(fail_cnt), 2);
      goto(54);
      chk("on_ready_back", 32'(cmd_ready), 1);
      goto(56); issue(OP_RSVD);
      goto(57); cmd_valid = 1'b0;
      chk("op7_ready_low", 32'(cmd_ready), 0);
      chk("op7_state", 32'(state_o), 1);

      // Freeze at lat=2, ack ignored while frozen, fail 2nd edge after thaw
      expect_ev(1'b1, 86);
      goto(60); req = 1'b1;
      goto(61); req = 1'b0;
      goto(62); issue(OP_FREEZE);
      goto(63); cmd_valid = 1'b0; ack = 1'b1;
      chk("frz_state", 32'(state_o), 2);
      chk("frz_busy", 32'(busy_o), 1);
      goto(81);
      chk("frz_busy_hold", 32'(busy_o), 1);
      chk("frz_pass_cnt", 32'(pass_cnt), 1);
      goto(83); ack = 1'b0;
      goto(84); issue(OP_THAW);
      goto(85); cmd_valid = 1'b0;
      chk("thaw_state", 32'(state_o), 1);
      goto(87);
      chk("thaw_fail_cnt", 32'(fail_cnt), 3);
      chk("thaw_small_fail_cnt", 32'(s_fail_cnt), 3);
      chk("thaw_ff_ts", 32'(first_fail_ts), 24);

      // Same, but ack at the 1st edge after thaw gives a pass
      expect_ev(1'b0, 101);
      goto(90); req = 1'b1;
      goto(91); req = 1'b0;
      goto(92); issue(OP_FREEZE);
      goto(93); cmd_valid = 1'b0; ack = 1'b1;
      goto(98); ack = 1'b0;
      goto(100); issue(OP_THAW);
      goto(101); cmd_valid = 1'b0; ack = 1'b1;
      goto(102); ack = 1'b0;
      chk("thaw_pass_cnt", 32'(pass_cnt), 2);

      // chk_en abort
      goto(110); req = 1'b1;
      goto(111); req = 1'b0;
      goto(112); chk_en = 1'b0;
      goto(113); chk_en = 1'b1;
      chk("abort_busy", 32'(busy_o), 0);

      // KILL abort
      goto(120); req = 1'b1;
      goto(121); req = 1'b0;
      goto(122); issue(OP_KILL);
      goto(123); cmd_valid = 1'b0;
      chk("kill_busy", 32'(busy_o), 0);
      chk("kill_state", 32'(state_o), 1);

      // CLR on the fail edge: fail wins
      expect_ev(1'b1, 134);
      goto(130); req = 1'b1;
      goto(131); req = 1'b0;
      goto(134); issue(OP_CLR);
      goto(135); cmd_valid = 1'b0;
      chk("clr_fail_cnt", 32'(fail_cnt), 1);
      chk("clr_pass_cnt", 32'(pass_cnt), 0);
      chk("clr_ff_vld", 32'(first_fail_vld), 1);
      chk("clr_ff_ts", 32'(first_fail_ts), 134);
      chk("clr_small_fail_cnt", 32'(s_fail_cnt), 1);

      // KILL with a completing ack and a new req: pass reported, no restart
      expect_ev(1'b0, 141);
      goto(140); req = 1'b1;
      goto(141); ack = 1'b1; issue(OP_KILL);
      goto(142); req = 1'b0; ack = 1'b0; cmd_valid = 1'b0;
      chk("killc_busy", 32'(busy_o), 0);
      chk("killc_pass_cnt", 32'(pass_cnt), 1);

      // Back-to-back: new req on the completion edge
      expect_ev(1'b0, 152);
      expect_ev(1'b0, 153);
      goto(150); req = 1'b1;
      goto(151); req = 1'b0;
      goto(152); req = 1'b1; ack = 1'b1;
      goto(153); req = 1'b0;
      chk("b2b_busy", 32'(busy_o), 1);
      goto(154); ack = 1'b0;
      chk("b2b_busy_done", 32'(busy_o), 0);
      chk("b2b_pass_cnt", 32'(pass_cnt), 3);
      chk("b2b_small_pass_cnt", 32'(s_pass_cnt), 3);

      // ack in the req cycle does not count
      expect_ev(1'b1, 164);
      goto(160); req = 1'b1; ack = 1'b1;
      goto(161); req = 1'b0; ack = 1'b0;
      goto(165);
      chk("reqack_fail_cnt", 32'(fail_cnt), 2);

      // Five fails since CLR: 2-bit counter saturates at 3
      for (int i = 0; i < 3; i++) begin
         expect_ev(1'b1, 174 + 10 * i);
         goto(170 + 10 * i); req = 1'b1;
         goto(171 + 10 * i); req = 1'b0;
      end
      goto(196);
      chk("sat_fail_cnt", 32'(fail_cnt), 5);
      chk("sat_small_fail_cnt", 32'(s_fail_cnt), 3);
      chk("sat_ff_ts", 32'(first_fail_ts), 134);

      // Async reset with lat=3 pending
      goto(200); req = 1'b1;
      goto(201); req = 1'b0;
      goto(203);
      chk("pre_rst_busy", 32'(busy_o), 1);
      #2 rst = 1'b1;
      #1 reset_checks("async_rst");
      @(negedge clk) rst = 1'b0;

      // Tracker live again after reset
      expect_ev(1'b0, 6);
      goto(5); req = 1'b1;
      goto(6); req = 1'b0; ack = 1'b1;
      goto(7); ack = 1'b0;
      goto(12);
      chk("post_rst_pass_cnt", 32'(pass_cnt), 1);
      chk("post_rst_fail_cnt", 32'(fail_cnt), 0);
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
